// File: rtl/riscv_pipe_ctrl.sv
// ---------------------------------------------------------------------------------------------
// riscv_pipe_ctrl
//   Decode and control unit for a 5-stage RV32I pipeline. It decodes the instruction in ID,
//   holds the ID/EX control register, resolves branches and jumps in EX, and detects load-use
//   hazards. From these it produces the IF/ID/EX stall and flush controls.
//
// Parameters
//   REG_AW      register-address width (rs1/rs2/rd fields)
//   EN_UBRANCH  1: decode bltu/bgeu, 0: treat them as illegal
//   EN_ILLEGAL  1: IllegalE reports undecodable instructions, 0: IllegalE tied low
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   instrD       instruction in ID
//   ZeroE/LtE/LtuE  ALU compare flags in EX (equal, signed less, unsigned less)
//   ImmSrcD      immediate select (combinational from instrD)
//   RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, RdE   registered EX controls
//   PCSrcE       00 PC+4, 01 PC+imm, 10 ALU (jalr)
//   StallF/StallD/FlushD/FlushE   pipeline-register controls
//   IllegalE     instruction in EX was undecodable
// ---------------------------------------------------------------------------------------------
module riscv_pipe_ctrl #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned EN_UBRANCH = 1,
   parameter int unsigned EN_ILLEGAL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instrD,
   input  logic              ZeroE,
   input  logic              LtE,
   input  logic              LtuE,
   output logic [2:0]        ImmSrcD,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              ALUSrcE,
   output logic [1:0]        ResultSrcE,
   output logic [2:0]        ALUControlE,
   output logic [REG_AW-1:0] RdE,
   output logic [1:0]        PCSrcE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic              IllegalE
);

   // Opcodes
   localparam logic [6:0] OpLoad   = 7'd3;
   localparam logic [6:0] OpImm    = 7'd19;
   localparam logic [6:0] OpStore  = 7'd35;
   localparam logic [6:0] OpReg    = 7'd51;
   localparam logic [6:0] OpLui    = 7'd55;
   localparam logic [6:0] OpBranch = 7'd99;
   localparam logic [6:0] OpJalr   = 7'd103;
   localparam logic [6:0] OpJal    = 7'd111;

   // Immediate selects
   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmJ = 3'b011;
   localparam logic [2:0] ImmU = 3'b100;

   // ALU operations
   localparam logic [2:0] AluAdd  = 3'b000;
   localparam logic [2:0] AluSub  = 3'b001;
   localparam logic [2:0] AluAnd  = 3'b010;
   localparam logic [2:0] AluOr   = 3'b011;
   localparam logic [2:0] AluXor  = 3'b100;
   localparam logic [2:0] AluSlt  = 3'b101;
   localparam logic [2:0] AluSltu = 3'b110;

   // Result selects
   localparam logic [1:0] ResAlu = 2'b00;
   localparam logic [1:0] ResMem = 2'b01;
   localparam logic [1:0] ResPc4 = 2'b10;
   localparam logic [1:0] ResImm = 2'b11;

   typedef enum logic [2:0] {
      BrNone = 3'd0,
      BrEq   = 3'd1,
      BrNe   = 3'd2,
      BrLt   = 3'd3,
      BrGe   = 3'd4,
      BrLtu  = 3'd5,
      BrGeu  = 3'd6
   } br_e;

   typedef struct packed {
      logic              reg_write;
      logic              mem_write;
      logic              alu_src;
      logic [1:0]        result_src;
      logic [2:0]        alu_ctrl;
      br_e               br;
      logic              jump;
      logic              jalr;
      logic [REG_AW-1:0] rd;
      logic              illegal;
   } ctrl_t;

   logic [6:0]        opc;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [REG_AW-1:0] rs1_d;
   logic [REG_AW-1:0] rs2_d;

   assign opc   = instrD[6:0];
   assign f3    = instrD[14:12];
   assign f7    = instrD[31:25];
   assign rs1_d = instrD[15 +: REG_AW];
   assign rs2_d = instrD[20 +: REG_AW];

   ctrl_t      dec;
   ctrl_t      ctrl_d;
   ctrl_t      ctrl_q;
   logic [2:0] imm_src;
   logic       legal;

   // ------------------------------------------------------------------------------------------
   // Decode (ID)
   // ------------------------------------------------------------------------------------------
   always_comb begin
      dec     = '0;
      imm_src = ImmI;
      legal   = 1'b0;
      case (opc)
         OpLoad: begin
            legal          = (f3 == 3'd2);
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = ResMem;
            dec.alu_ctrl   = AluAdd;
         end
         OpImm: begin
            legal         = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            case (f3)
               3'd0:    dec.alu_ctrl = AluAdd;
               3'd4:    dec.alu_ctrl = AluXor;
               3'd6:    dec.alu_ctrl = AluOr;
               3'd2:    dec.alu_ctrl = AluSlt;
               3'd3:    dec.alu_ctrl = AluSltu;
               default: legal = 1'b0;
            endcase
         end
         OpStore: begin
            legal         = (f3 == 3'd2);
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = AluAdd;
            imm_src       = ImmS;
         end
         OpReg: begin
            legal         = 1'b1;
            dec.reg_write = 1'b1;
            case (f3)
               3'd0: begin
                  if (f7 == 7'd0) begin
                     dec.alu_ctrl = AluAdd;
                  end else if (f7 == 7'd32) begin
                     dec.alu_ctrl = AluSub;
                  end else begin
                     legal = 1'b0;
                  end
               end
               3'd7:    dec.alu_ctrl = AluAnd;
               3'd6:    dec.alu_ctrl = AluOr;
               3'd2:    dec.alu_ctrl = AluSlt;
               3'd3:    dec.alu_ctrl = AluSltu;
               default: legal = 1'b0;
            endcase
            // Only add/sub have an alternate funct7 encoding
            if (f3 != 3'd0 && f7 != 7'd0) begin
               legal = 1'b0;
            end
         end
         OpLui: begin
            legal          = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = ResImm;
            imm_src        = ImmU;
         end
         OpBranch: begin
            legal        = 1'b1;
            dec.alu_ctrl = AluSub;
            imm_src      = ImmB;
            case (f3)
               3'd0: dec.br = BrEq;
               3'd1: dec.br = BrNe;
               3'd4: dec.br = BrLt;
               3'd5: dec.br = BrGe;
               3'd6: begin
                  if (EN_UBRANCH != 0) dec.br = BrLtu;
                  else                 legal  = 1'b0;
               end
               3'd7: begin
                  if (EN_UBRANCH != 0) dec.br = BrGeu;
                  else                 legal  = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OpJalr: begin
            legal          = (f3 == 3'd0);
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = ResPc4;
            dec.alu_ctrl   = AluAdd;
            dec.jalr       = 1'b1;
         end
         OpJal: begin
            legal          = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = ResPc4;
            dec.jump       = 1'b1;
            imm_src        = ImmJ;
         end
         default: legal = 1'b0;
      endcase

      if (legal) begin
         dec.rd = instrD[7 +: REG_AW];
      end else begin
         // Undecodable (including the all-zero reset bubble): everything off
         dec     = '0;
         imm_src = ImmI;
      end
      dec.illegal = ~legal & (EN_ILLEGAL != 0);
   end

   assign ImmSrcD = imm_src;

   // ------------------------------------------------------------------------------------------
   // ID/EX control register
   // ------------------------------------------------------------------------------------------
   assign ctrl_d = FlushE ? '0 : dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign RegWriteE   = ctrl_q.reg_write;
   assign MemWriteE   = ctrl_q.mem_write;
   assign ALUSrcE     = ctrl_q.alu_src;
   assign ResultSrcE  = ctrl_q.result_src;
   assign ALUControlE = ctrl_q.alu_ctrl;
   assign RdE         = ctrl_q.rd;
   assign IllegalE    = (EN_ILLEGAL != 0) ? ctrl_q.illegal : 1'b0;

   // ------------------------------------------------------------------------------------------
   // Branch resolution (EX)
   // ------------------------------------------------------------------------------------------
   logic taken;
   logic redirect;

   always_comb begin
      taken = 1'b0;
      case (ctrl_q.br)
         BrEq:    taken = ZeroE;
         BrNe:    taken = ~ZeroE;
         BrLt:    taken = LtE;
         BrGe:    taken = ~LtE;
         BrLtu:   taken = LtuE;
         BrGeu:   taken = ~LtuE;
         default: taken = 1'b0;
      endcase
   end

   assign PCSrcE   = ctrl_q.jalr                ? 2'b10 :
                     (ctrl_q.jump | taken)      ? 2'b01 : 2'b00;
   assign redirect = (PCSrcE != 2'b00);

   // ------------------------------------------------------------------------------------------
   // Load-use hazard
   // ------------------------------------------------------------------------------------------
   logic uses_rs1;
   logic uses_rs2;
   logic lw_stall;

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opc)
         OpLoad, OpImm, OpJalr:     uses_rs1 = 1'b1;
         OpStore, OpReg, OpBranch: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         default: ;
      endcase
   end

   assign lw_stall = (ctrl_q.result_src == ResMem) & ctrl_q.reg_write &
                     (ctrl_q.rd != '0) &
                     (((ctrl_q.rd == rs1_d) & uses_rs1) | ((ctrl_q.rd == rs2_d) & uses_rs2));

   // A redirect wins: the instruction being stalled is about to be discarded anyway
   assign StallF = lw_stall & ~redirect;
   assign StallD = lw_stall & ~redirect;
   assign FlushD = redirect;
   assign FlushE = lw_stall | redirect;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
module tb_riscv_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instrD;
   logic        ZeroE, LtE, LtuE;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] imm;
      logic       rw;
      logic       mw;
      logic       as;
      logic [1:0] rs;
      logic [2:0] alu;
      logic [4:0] rd;
      logic [1:0] pc;
      logic       sf;
      logic       sd;
      logic       fd;
      logic       fe;
      logic       il;
   } vec_t;

   typedef struct packed {
      logic [15:0] step;
      vec_t        e;
      logic        chk_nu;
      vec_t        e_nu;
   } exp_t;

   // Default DUT
   logic [2:0] imm_a, alu_a;
   logic       rw_a, mw_a, as_a, sf_a, sd_a, fd_a, fe_a, il_a;
   logic [1:0] rs_a, pc_a;
   logic [4:0] rd_a;

   riscv_pipe_ctrl #(.REG_AW(5), .EN_UBRANCH(1), .EN_ILLEGAL(1)) dut (
      .clk(clk), .rst_n(rst_n), .instrD(instrD), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
      .ImmSrcD(imm_a), .RegWriteE(rw_a), .MemWriteE(mw_a), .ALUSrcE(as_a),
      .ResultSrcE(rs_a), .ALUControlE(alu_a), .RdE(rd_a), .PCSrcE(pc_a),
      .StallF(sf_a), .StallD(sd_a), .FlushD(fd_a), .FlushE(fe_a), .IllegalE(il_a)
   );

   // Unsigned branches disabled
   logic [2:0] imm_b, alu_b;
   logic       rw_b, mw_b, as_b, sf_b, sd_b, fd_b, fe_b, il_b;
   logic [1:0] rs_b, pc_b;
   logic [4:0] rd_b;

   riscv_pipe_ctrl #(.REG_AW(5), .EN_UBRANCH(0), .EN_ILLEGAL(1)) dut_nu (
      .clk(clk), .rst_n(rst_n), .instrD(instrD), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
      .ImmSrcD(imm_b), .RegWriteE(rw_b), .MemWriteE(mw_b), .ALUSrcE(as_b),
      .ResultSrcE(rs_b), .ALUControlE(alu_b), .RdE(rd_b), .PCSrcE(pc_b),
      .StallF(sf_b), .StallD(sd_b), .FlushD(fd_b), .FlushE(fe_b), .IllegalE(il_b)
   );

   vec_t act_a, act_b;
   assign act_a = {imm_a, rw_a, mw_a, as_a, rs_a, alu_a, rd_a, pc_a, sf_a, sd_a, fd_a, fe_a, il_a};
   assign act_b = {imm_b, rw_b, mw_b, as_b, rs_b, alu_b, rd_b, pc_b, sf_b, sd_b, fd_b, fe_b, il_b};

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;
   int   step_n = 0;
   logic nu_on  = 1'b1;

   // Instruction encodings
   localparam logic [31:0] IAdd3    = 32'h002081B3;  // add  x3,x1,x2
   localparam logic [31:0] ISub0    = 32'h40208033;  // sub  x0,x1,x2
   localparam logic [31:0] INop     = 32'h00000013;  // addi x0,x0,0
   localparam logic [31:0] ILw5     = 32'h0000A283;  // lw   x5,0(x1)
   localparam logic [31:0] IAdd6    = 32'h00728333;  // add  x6,x5,x7
   localparam logic [31:0] ILw6     = 32'h0002A303;  // lw   x6,0(x5)
   localparam logic [31:0] ILw0     = 32'h0000A003;  // lw   x0,0(x1)
   localparam logic [31:0] IAdd6x0  = 32'h00700333;  // add  x6,x0,x7
   localparam logic [31:0] IBne     = 32'h00209463;  // bne  x1,x2,+8
   localparam logic [31:0] IBltu    = 32'h0020E463;  // bltu x1,x2,+8
   localparam logic [31:0] IJalr    = 32'h000100E7;  // jalr x1,0(x2)
   localparam logic [31:0] IAdd4    = 32'h00108233;  // add  x4,x1,x1
   localparam logic [31:0] ILui     = 32'h123453B7;  // lui  x7,0x12345
   localparam logic [31:0] ISw      = 32'h0020A223;  // sw   x2,4(x1)
   localparam logic [31:0] IJal     = 32'h010000EF;  // jal  x1,+16
   localparam logic [31:0] IBad     = 32'hFFFFFFFF;

   function automatic vec_t mk(int unsigned imm, int unsigned rw, int unsigned mw,
                               int unsigned as, int unsigned rs, int unsigned alu,
                               int unsigned rd, int unsigned pc, int unsigned sf,
                               int unsigned sd, int unsigned fd, int unsigned fe,
                               int unsigned il);
      vec_t v;
      v.imm = imm[2:0];
      v.rw  = rw[0];
      v.mw  = mw[0];
      v.as  = as[0];
      v.rs  = rs[1:0];
      v.alu = alu[2:0];
      v.rd  = rd[4:0];
      v.pc  = pc[1:0];
      v.sf  = sf[0];
      v.sd  = sd[0];
      v.fd  = fd[0];
      v.fe  = fe[0];
      v.il  = il[0];
      return v;
   endfunction

   // Apply one cycle of inputs just after a rising edge and queue what both DUTs must show
   task automatic step2(input logic rst, input logic [31:0] ins, input logic z, input logic lt,
                        input logic ltu, input vec_t e, input vec_t e_nu);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n  = rst;
      instrD = ins;
      ZeroE  = z;
      LtE    = lt;
      LtuE   = ltu;
      x.step   = 16'(step_n);
      x.e      = e;
      x.chk_nu = nu_on;
      x.e_nu   = e_nu;
      q.push_back(x);
      step_n++;
   endtask

   task automatic step(input logic rst, input logic [31:0] ins, input logic z, input logic lt,
                       input logic ltu, input vec_t e);
      step2(rst, ins, z, lt, ltu, e, e);
   endtask

   // Monitor: outputs are presented every cycle, checked mid-cycle
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            total++;
            if (act_a === x.e) passed++;
            else $display("FAIL step%0d dut: got %h required %h", x.step, act_a, x.e);
            if (x.chk_nu) begin
               total++;
               if (act_b === x.e_nu) passed++;
               else $display("FAIL step%0d dut_nu: got %h required %h", x.step, act_b, x.e_nu);
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      instrD = IAdd3;
      ZeroE  = 1'b0;
      LtE    = 1'b0;
      LtuE   = 1'b0;

      // Reset held, then released with add in ID
      step(0, IAdd3, 0, 0, 0, '0);
      step(0, IAdd3, 0, 0, 0, '0);
      step(1, IAdd3, 0, 0, 0, '0);
      step(1, ISub0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      step(1, INop,  0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      // Load-use: one stall cycle, then the add issues
      step(1, ILw5,  0, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(1, IAdd6, 0, 0, 0, mk(0, 1, 0, 1, 1, 0, 5, 0, 1, 1, 0, 1, 0));
      step(1, IAdd6, 0, 0, 0, '0);
      step(1, ILw5,  0, 0, 0, mk(0, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0));
      // lw -> lw dependence
      step(1, ILw6,  0, 0, 0, mk(0, 1, 0, 1, 1, 0, 5, 0, 1, 1, 0, 1, 0));
      step(1, ILw6,  0, 0, 0, '0);
      step(1, ILw0,  0, 0, 0, mk(0, 1, 0, 1, 1, 0, 6, 0, 0, 0, 0, 0, 0));
      // Load to x0 never stalls
      step(1, IAdd6x0, 0, 0, 0, mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      // bne taken, then not taken
      step(1, IBne,  0, 0, 0, mk(2, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0));
      step(1, INop,  0, 0, 0, mk(0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1, 1, 0));
      step(1, IBne,  1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(1, INop,  1, 0, 0, mk(0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0));
      // bltu: taken with unsigned compare only; illegal when unsigned branches are disabled
      step2(1, IBltu, 1, 0, 1, mk(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                               mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step2(1, INop,  1, 0, 1, mk(0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1, 1, 0),
                               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      nu_on = 1'b0;
      // jalr redirect while a dependent instruction sits in ID
      step(1, IJalr, 0, 0, 0, '0);
      step(1, IAdd4, 0, 0, 0, mk(0, 1, 0, 1, 2, 0, 1, 2, 0, 0, 1, 1, 0));
      step(1, ILui,  0, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(1, ISw,   0, 0, 0, mk(1, 1, 0, 0, 3, 0, 7, 0, 0, 0, 0, 0, 0));
      step(1, IJal,  0, 0, 0, mk(3, 0, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0));
      step(1, IBad,  0, 0, 0, mk(0, 1, 0, 0, 2, 0, 1, 1, 0, 0, 1, 1, 0));
      step(1, IBad,  0, 0, 0, '0);
      step(1, 32'h0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(1, ILw5,  0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // Reset mid-operation with a load in EX and a dependent add in ID
      step(0, IAdd6, 0, 0, 0, '0);
      step(1, INop,  0, 0, 0, '0);
      step(1, INop,  0, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
